// File: rtl/aes_pkg.sv
// Shared AES constants and helper functions for the iterative decryptor:
// S-box tables, round constants, GF(2^8) arithmetic and the controller state encoding.
package aes_pkg;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXPAND = 3'd1,
        ADDKEY = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } aes_state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        return RCON[79 - 8*int'(idx) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last_rnd,
    output logic [127:0] res
);

    logic [127:0] sr_s;
    logic [127:0] ak_s;

    // Row r rotates right by r columns; byte 4*c+r sits at bits [127-8*(4*c+r) -: 8]
    always_comb begin
        sr_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[127 - 8*(4*c + r) -: 8] = st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
    end

    // Inverse S-box on every byte, then mix in the round key
    always_comb begin
        ak_s = 128'h0;
        for (int k = 0; k < 16; k++) begin
            ak_s[127 - 8*k -: 8] = inv_sbox(sr_s[127 - 8*k -: 8]) ^ rk[127 - 8*k -: 8];
        end
    end

    // Column mixing is bypassed on the round that uses rk[0]
    always_comb begin
        res = 128'h0;
        if (last_rnd) begin
            res = ak_s;
        end else begin
            for (int c = 0; c < 4; c++) begin
                res[127 - 32*c -: 32] = inv_mix_column(ak_s[127 - 32*c -: 32]);
            end
        end
    end

endmodule

// File: rtl/aes_decipher_iter.sv
// Iterative AES-128/192/256 decryptor: on-chip key expansion, then one inverse round per clock.
// Optional macro AES_DEC_KEY_CACHE_EN keeps the last expanded key and skips expansion on a repeat key.
module aes_decipher_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_decipher_iter: KEY_BITS must be 128, 192 or 256");
    end

    aes_state_e   state_r, state_s;
    logic [31:0]  w_r [NW];
    logic [5:0]   wi_r;
    logic [2:0]   kmod_r;
    logic [3:0]   rc_r;
    logic [3:0]   rnd_r;
    logic [127:0] st_r;
    logic [127:0] cdata_r;
    logic [127:0] out_data_r;
    logic         out_valid_r;
    logic         in_ready_r;

    logic         hit_s;
    logic [31:0]  prev_s, old_s, t_s;
    logic [3:0]   rk_idx_s;
    logic [5:0]   wb_s;
    logic [127:0] rk_s;
    logic [127:0] round_s;
    logic         accept_s;

    assign accept_s  = (state_r == IDLE) && in_valid;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [KEY_BITS-1:0] key_copy_r;
    logic                key_ok_r;

    assign hit_s = key_ok_r && (in_key == key_copy_r);

    // Cache tag: remember the key being expanded, valid only once expansion completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_copy_r <= {KEY_BITS{1'b0}};
            key_ok_r   <= 1'b0;
        end else if (accept_s && !hit_s) begin
            key_copy_r <= in_key;
            key_ok_r   <= 1'b0;
        end else if (state_r == EXPAND && wi_r == 6'(NW - 1)) begin
            key_ok_r   <= 1'b1;
        end
    end
`else
    assign hit_s = 1'b0;
`endif

    // Key schedule step for word wi_r
    always_comb begin
        prev_s = w_r[wi_r - 6'd1];
        old_s  = w_r[wi_r - 6'(NK)];
        if (kmod_r == 3'd0) begin
            t_s = sub_word(rot_word(prev_s)) ^ {rcon(rc_r), 24'h000000};
        end else if (NK == 8 && kmod_r == 3'd4) begin
            t_s = sub_word(prev_s);
        end else begin
            t_s = prev_s;
        end
    end

    // Round key select: ADDKEY uses the final schedule entry, ROUND walks down from NR-1
    always_comb begin
        if (state_r == ADDKEY) begin
            rk_idx_s = 4'(NR);
        end else begin
            rk_idx_s = rnd_r;
        end
        wb_s = {rk_idx_s, 2'b00};
        rk_s = {w_r[wb_s], w_r[wb_s + 6'd1], w_r[wb_s + 6'd2], w_r[wb_s + 6'd3]};
    end

    aes_inv_round_comb u_round (
        .st       (st_r),
        .rk       (rk_s),
        .last_rnd (rnd_r == 4'd0),
        .res      (round_s)
    );

    // Controller next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = hit_s ? ADDKEY : EXPAND;
                end else begin
                    state_s = IDLE;
                end
            end
            EXPAND: begin
                if (wi_r == 6'(NW - 1)) begin
                    state_s = ADDKEY;
                end else begin
                    state_s = EXPAND;
                end
            end
            ADDKEY: state_s = ROUND;
            ROUND: begin
                if (rnd_r == 4'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = ROUND;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Control, counters and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 128'h0;
            wi_r        <= 6'd0;
            kmod_r      <= 3'd0;
            rc_r        <= 4'd0;
            rnd_r       <= 4'd0;
            st_r        <= 128'h0;
            cdata_r     <= 128'h0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        cdata_r <= in_data;
                        wi_r    <= 6'(NK);
                        kmod_r  <= 3'd0;
                        rc_r    <= 4'd0;
                    end
                end
                EXPAND: begin
                    wi_r <= wi_r + 6'd1;
                    if (kmod_r == 3'(NK - 1)) begin
                        kmod_r <= 3'd0;
                        rc_r   <= rc_r + 4'd1;
                    end else begin
                        kmod_r <= kmod_r + 3'd1;
                    end
                end
                ADDKEY: begin
                    st_r  <= cdata_r ^ rk_s;
                    rnd_r <= 4'(NR - 1);
                end
                ROUND: begin
                    if (rnd_r == 4'd0) begin
                        out_data_r  <= round_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        st_r  <= round_s;
                        rnd_r <= rnd_r - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key word file; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (accept_s && !hit_s) begin
            for (int k = 0; k < NK; k++) begin
                w_r[k] <= in_key[KEY_BITS - 1 - 32*k -: 32];
            end
        end else if (state_r == EXPAND) begin
            w_r[wi_r] <= old_s ^ t_s;
        end
    end

endmodule

// File: tb/tb_aes_decipher_iter.sv
// Directed bench for aes_decipher_iter: FIPS-197 vectors at all three key sizes,
// backpressure, mid-round reset and (with AES_DEC_KEY_CACHE_EN) key-cache hits.
module tb_aes_decipher_iter;

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam int REPEAT_LAT = 15;
`else
    localparam int REPEAT_LAT = 67;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    int n_chk;
    int n_fail;

    aes_decipher_iter #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_key(key128), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));
    aes_decipher_iter #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_key(key192), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));
    aes_decipher_iter #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .in_key(key256), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic set_key(input int d, input logic [255:0] key);
        if (d == 0) begin
            key128 = key[127:0];
        end else if (d == 1) begin
            key192 = key[191:0];
        end else begin
            key256 = key;
        end
    endtask

    // Offer one block, scramble inputs after accept, measure edges until out_valid
    task automatic run_block(input int d, input logic [255:0] key, input logic [127:0] ct,
                             input int exp_lat, input logic [127:0] exp_pt, input bit chk_pt,
                             input string tag);
        int lat;
        @(negedge clk);
        set_key(d, key);
        in_data[d]  = ct;
        in_valid[d] = 1'b1;
        chk({tag, "_in_ready"}, 128'(in_ready[d]), 128'd1);
        @(posedge clk);
        #1;
        in_data[d] = ~ct;
        set_key(d, ~key);
        lat = 0;
        while (!out_valid[d] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid[d] = 1'b0;
        set_key(d, key);
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        if (chk_pt) begin
            chk({tag, "_pt"}, out_data[d], exp_pt);
        end
    endtask

    task automatic release_out(input int d, input string tag);
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rel_out_valid"}, 128'(out_valid[d]), 128'd0);
        chk({tag, "_rel_in_ready"}, 128'(in_ready[d]), 128'd1);
        out_ready[d] = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        key128 = K128;
        key192 = K192;
        key256 = K256;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = 128'h0;
            out_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_out_valid", 128'(out_valid[d]), 128'd0);
            chk("reset_in_ready", 128'(in_ready[d]), 128'd1);
            chk("reset_out_data", out_data[d], 128'h0);
        end

        run_block(0, 256'(K128), CT128, 51, PT, 1'b1, "t1_aes128");
        release_out(0, "t1");
        run_block(1, 256'(K192), CT192, 59, PT, 1'b1, "t2_aes192");
        release_out(1, "t2");
        run_block(2, K256, CT256, 67, PT, 1'b1, "t3_aes256");

        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_data", out_data[2], PT);
            chk("t4_hold_valid", 128'(out_valid[2]), 128'd1);
            chk("t4_in_ready_low", 128'(in_ready[2]), 128'd0);
        end
        release_out(2, "t4");

        run_block(2, K256, CT256, REPEAT_LAT, PT, 1'b1, "t6_repeat");
        release_out(2, "t6a");
        run_block(2, K256 ^ 256'h1, CT256, 67, PT, 1'b0, "t6_newkey");
        release_out(2, "t6b");
        run_block(2, K256, CT256, 67, PT, 1'b1, "t6_oldkey");
        release_out(2, "t6c");

        @(negedge clk);
        in_data[2]  = CT256;
        in_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[2] = 1'b0;
        repeat (56) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", 128'(out_valid[2]), 128'd0);
        chk("t5_rst_in_ready", 128'(in_ready[2]), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        run_block(2, K256, CT256, 67, PT, 1'b1, "t5_rerun");
        release_out(2, "t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
